// File: rtl/fp_multiplier_16_bit.sv
// fp_multiplier_16_bit: 3-stage pipelined binary16 multiplier.
// Stage 1 unpacks and classifies operands, stage 2 forms the 22-bit
// significand product, stage 3 normalises, rounds and registers the
// result and flags. Subnormal inputs and results are flushed to zero.
// The whole pipe advances together and holds on output backpressure.
module fp_multiplier_16_bit #(
    parameter logic [15:0] QNAN_VALUE = 16'h7E00,
    parameter int unsigned ROUND_MODE = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        zero_flag,
    output logic        infinity_flag,
    output logic        NaN_flag
);

    typedef enum logic [1:0] {
        CLS_FINITE,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } class_t;

    logic advance;

    // Stage 1 registers
    logic              s1_valid;
    logic              s1_sign;
    class_t            s1_class;
    logic signed [6:0] s1_exp;
    logic [10:0]       s1_mant_a;
    logic [10:0]       s1_mant_b;

    // Stage 2 registers
    logic              s2_valid;
    logic              s2_sign;
    class_t            s2_class;
    logic signed [6:0] s2_exp;
    logic [21:0]       s2_prod;

    // Stage 1 combinational
    logic [4:0]        ea, eb;
    logic [9:0]        ma, mb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    class_t            in_class;
    logic signed [6:0] in_exp_sum;

    // Stage 2 combinational
    logic [21:0]       prod;

    // Stage 3 combinational
    logic [10:0]       norm_mant;
    logic              guard_bit;
    logic              sticky_bit;
    logic              round_up;
    logic signed [6:0] norm_exp;
    logic [11:0]       mant_sum;
    logic signed [6:0] final_exp;
    logic [9:0]        final_frac;
    logic [15:0]       next_result;
    logic              next_overflow;
    logic              next_underflow;
    logic              next_zero;
    logic              next_infinity;
    logic              next_nan;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Unpack operands, classify the pair and form the unbiased exponent sum
    always_comb begin
        ea = operand_a[14:10];
        eb = operand_b[14:10];
        ma = operand_a[9:0];
        mb = operand_b[9:0];
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        a_inf  = (ea == 5'h1F) && (ma == 10'd0);
        b_inf  = (eb == 5'h1F) && (mb == 10'd0);
        a_nan  = (ea == 5'h1F) && (ma != 10'd0);
        b_nan  = (eb == 5'h1F) && (mb != 10'd0);
        in_class = CLS_FINITE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            in_class = CLS_NAN;
        end else if (a_inf || b_inf) begin
            in_class = CLS_INF;
        end else if (a_zero || b_zero) begin
            in_class = CLS_ZERO;
        end
        in_exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
    end

    // Significand product with hidden bits included
    always_comb begin
        prod = {11'd0, s1_mant_a} * {11'd0, s1_mant_b};
    end

    // Normalise, round, and resolve specials / range limits into the output word
    always_comb begin
        if (s2_prod[21]) begin
            norm_mant  = s2_prod[21:11];
            guard_bit  = s2_prod[10];
            sticky_bit = |s2_prod[9:0];
            norm_exp   = s2_exp + 7'sd1;
        end else begin
            norm_mant  = s2_prod[20:10];
            guard_bit  = s2_prod[9];
            sticky_bit = |s2_prod[8:0];
            norm_exp   = s2_exp;
        end
        round_up = (ROUND_MODE == 0) ? (guard_bit && (sticky_bit || norm_mant[0])) : 1'b0;
        mant_sum = {1'b0, norm_mant} + {11'd0, round_up};
        // A carry out of rounding leaves 1.000..0, so bump the exponent
        if (mant_sum[11]) begin
            final_exp  = norm_exp + 7'sd1;
            final_frac = mant_sum[10:1];
        end else begin
            final_exp  = norm_exp;
            final_frac = mant_sum[9:0];
        end

        next_result    = '0;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;
        next_zero      = 1'b0;
        next_infinity  = 1'b0;
        next_nan       = 1'b0;
        case (s2_class)
            CLS_NAN: begin
                next_result = QNAN_VALUE;
                next_nan    = 1'b1;
            end
            CLS_INF: begin
                next_result   = {s2_sign, 5'h1F, 10'd0};
                next_infinity = 1'b1;
            end
            CLS_ZERO: begin
                next_result = {s2_sign, 15'd0};
                next_zero   = 1'b1;
            end
            default: begin
                if (final_exp >= 7'sd31) begin
                    next_result   = {s2_sign, 5'h1F, 10'd0};
                    next_overflow = 1'b1;
                    next_infinity = 1'b1;
                end else if (final_exp <= 7'sd0) begin
                    next_result    = {s2_sign, 15'd0};
                    next_underflow = 1'b1;
                    next_zero      = 1'b1;
                end else begin
                    next_result = {s2_sign, final_exp[4:0], final_frac};
                end
            end
        endcase
    end

    // Pipeline registers: every stage moves on advance, holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_class       <= CLS_FINITE;
            s1_exp         <= '0;
            s1_mant_a      <= '0;
            s1_mant_b      <= '0;
            s2_valid       <= 1'b0;
            s2_sign        <= 1'b0;
            s2_class       <= CLS_FINITE;
            s2_exp         <= '0;
            s2_prod        <= '0;
            out_valid      <= 1'b0;
            result         <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            zero_flag      <= 1'b0;
            infinity_flag  <= 1'b0;
            NaN_flag       <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sign   <= operand_a[15] ^ operand_b[15];
            s1_class  <= in_class;
            s1_exp    <= in_exp_sum;
            s1_mant_a <= {1'b1, ma};
            s1_mant_b <= {1'b1, mb};
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_class  <= s1_class;
            s2_exp    <= s1_exp;
            s2_prod   <= prod;
            out_valid <= s2_valid;
            // Output word only changes when a real entry arrives
            if (s2_valid) begin
                result         <= next_result;
                overflow_flag  <= next_overflow;
                underflow_flag <= next_underflow;
                zero_flag      <= next_zero;
                infinity_flag  <= next_infinity;
                NaN_flag       <= next_nan;
            end
        end
    end

endmodule
